// File: rtl/rv32_mod_mem_arbiter.sv
// Two-requester arbiter sharing one req/ack/err memory port between instruction fetch and load/store.
// Define RV32_MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data wins every tie.
module rv32_mod_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_data_o,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data_i,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_data_o,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_data_i,
  output logic        busy
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GNT_I = 2'd1,
    S_GNT_D = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic            r_wr;
  logic [3:0]      r_be;
  logic [31:0]     r_wdata;

  logic            w_granted;
  logic            w_resp;
  logic            w_timeout;
  logic            w_done;
  logic            w_load_i;
  logic            w_load_d;
  logic            w_tie_d;

  assign w_granted = (r_state != S_IDLE);
  assign w_resp    = mem_ack | mem_err;
  assign w_timeout = (TIMEOUT != 0) && w_granted && (r_cnt == CW'(TIMEOUT));
  assign w_done    = w_resp | w_timeout;

`ifdef RV32_MEM_ARB_ROUND_ROBIN_EN
  // Tie goes to whoever was not granted last; reset value points at instr so data wins first.
  logic r_last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (w_load_i | w_load_d) begin
      r_last_d <= w_load_d;
    end
  end

  assign w_tie_d = ~r_last_d;
`else
  assign w_tie_d = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Completed requester is never re-granted in its own completion cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_load_i    = 1'b0;
    w_load_d    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_req && (!instr_req || w_tie_d)) begin
          w_load_d    = 1'b1;
          w_state_nxt = S_GNT_D;
        end else if (instr_req) begin
          w_load_i    = 1'b1;
          w_state_nxt = S_GNT_I;
        end
      end
      S_GNT_I: begin
        if (w_done) begin
          if (data_req) begin
            w_load_d    = 1'b1;
            w_state_nxt = S_GNT_D;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GNT_D: begin
        if (w_done) begin
          if (instr_req) begin
            w_load_i    = 1'b1;
            w_state_nxt = S_GNT_I;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_load_d) begin
      r_addr  <= data_addr;
      r_wr    <= data_wr;
      r_be    <= data_be;
      r_wdata <= data_data_i;
    end else if (w_load_i) begin
      r_addr  <= instr_addr;
      r_wr    <= 1'b0;
      r_be    <= 4'hF;
      r_wdata <= '0;
    end
  end

  // Watchdog counts granted cycles without a response; cleared on every new grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_load_i || w_load_d || !w_granted) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    mem_req      = w_granted;
    busy         = w_granted;
    mem_addr     = '0;
    mem_wr       = 1'b0;
    mem_be       = '0;
    mem_data_o   = '0;
    instr_ack    = 1'b0;
    instr_err    = 1'b0;
    instr_data_o = '0;
    data_ack     = 1'b0;
    data_err     = 1'b0;
    data_data_o  = '0;
    case (r_state)
      S_GNT_I: begin
        mem_addr   = r_addr;
        mem_be     = 4'hF;
        mem_data_o = r_wdata;
        instr_ack  = mem_ack & ~mem_err;
        instr_err  = mem_err | (w_timeout & ~mem_ack);
        if (mem_ack && !mem_err) begin
          instr_data_o = mem_data_i;
        end
      end
      S_GNT_D: begin
        mem_addr   = r_addr;
        mem_wr     = r_wr;
        mem_be     = r_be;
        mem_data_o = r_wdata;
        data_ack   = mem_ack & ~mem_err;
        data_err   = mem_err | (w_timeout & ~mem_ack);
        if (mem_ack && !mem_err) begin
          data_data_o = mem_data_i;
        end
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rv32_mod_mem_arbiter.sv
// Self-checking bench for rv32_mod_mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_rv32_mod_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic        instr_err;
  logic [31:0] instr_data_o;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_data_i;
  logic        data_ack;
  logic        data_err;
  logic [31:0] data_data_o;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_o;
  logic        mem_ack;
  logic        mem_err;
  logic [31:0] mem_data_i;
  logic        busy;

  int n_checks;
  int n_fail;

  rv32_mod_mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_ack    (instr_ack),
    .instr_err    (instr_err),
    .instr_data_o (instr_data_o),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_be      (data_be),
    .data_addr    (data_addr),
    .data_data_i  (data_data_i),
    .data_ack     (data_ack),
    .data_err     (data_err),
    .data_data_o  (data_data_o),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_be       (mem_be),
    .mem_addr     (mem_addr),
    .mem_data_o   (mem_data_o),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err),
    .mem_data_i   (mem_data_i),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_req   = 1'b0;
    instr_addr  = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_be     = '0;
    data_addr   = '0;
    data_data_i = '0;
    mem_ack     = 1'b0;
    mem_err     = 1'b0;
    mem_data_i  = '0;
  endtask

  // Leaves the bench just after a rising edge with reset released: that cycle is cycle 0.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #3;
    n_checks++;
    if ({mem_req, busy, mem_wr, mem_be, mem_addr, mem_data_o} !== 70'h0) begin
      n_fail++;
      $display("FAIL reset_mem_side: got %h expected 0", {mem_req, busy, mem_wr, mem_be, mem_addr, mem_data_o});
    end
    n_checks++;
    if ({instr_ack, instr_err, instr_data_o, data_ack, data_err, data_data_o} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_responses: got %h expected 0",
               {instr_ack, instr_err, instr_data_o, data_ack, data_err, data_data_o});
    end
    instr_req = 1'b1;
    data_req  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_req, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_holds_idle: got %b expected 00", {mem_req, busy});
    end
    clear_inputs();
  endtask

  task automatic test_single_read(input string tag);
    instr_req  = 1'b1;
    instr_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_c0_mem_req: got %b expected 0", tag, mem_req);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_addr, mem_wr, mem_be} !== {1'b1, 32'h100, 1'b0, 4'hF}) begin
      n_fail++;
      $display("FAIL %s_c1_cmd: got %h expected %h", tag, {mem_req, mem_addr, mem_wr, mem_be},
               {1'b1, 32'h100, 1'b0, 4'hF});
    end
    tick();
    mem_data_i = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++;
    if ({instr_ack, instr_err, instr_data_o} !== 34'h0) begin
      n_fail++;
      $display("FAIL %s_c2_no_resp: got %h expected 0", tag, {instr_ack, instr_err, instr_data_o});
    end
    tick();
    mem_ack    = 1'b1;
    mem_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if ({instr_ack, instr_err, instr_data_o} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL %s_c3_ack: got %h expected %h", tag, {instr_ack, instr_err, instr_data_o},
               {1'b1, 1'b0, 32'hDEAD_BEEF});
    end
    tick();
    instr_req  = 1'b0;
    mem_ack    = 1'b0;
    mem_data_i = '0;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_c4_idle: got %b expected 00", tag, {busy, mem_req});
    end
  endtask

  task automatic test_priority();
    do_reset();
    instr_req   = 1'b1;
    instr_addr  = 32'h300;
    data_req    = 1'b1;
    data_wr     = 1'b1;
    data_addr   = 32'h2000;
    data_be     = 4'b0011;
    data_data_i = 32'h55AA;
    tick();
    mem_ack    = 1'b1;
    mem_data_i = 32'h1111;
    @(negedge clk);
    n_checks++;
    if ({mem_req, mem_wr, mem_addr, mem_be, mem_data_o} !== {1'b1, 1'b1, 32'h2000, 4'b0011, 32'h55AA}) begin
      n_fail++;
      $display("FAIL prio_data_cmd: got %h expected %h", {mem_req, mem_wr, mem_addr, mem_be, mem_data_o},
               {1'b1, 1'b1, 32'h2000, 4'b0011, 32'h55AA});
    end
    n_checks++;
    if ({data_ack, data_err, data_data_o, instr_ack} !== {1'b1, 1'b0, 32'h1111, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_data_ack: got %h expected %h", {data_ack, data_err, data_data_o, instr_ack},
               {1'b1, 1'b0, 32'h1111, 1'b0});
    end
    tick();
    data_req   = 1'b0;
    data_wr    = 1'b0;
    mem_data_i = 32'h1234;
    @(negedge clk);
    n_checks++;
    if ({busy, mem_req, mem_wr, mem_addr, mem_be} !== {1'b1, 1'b1, 1'b0, 32'h300, 4'hF}) begin
      n_fail++;
      $display("FAIL prio_b2b_instr_cmd: got %h expected %h", {busy, mem_req, mem_wr, mem_addr, mem_be},
               {1'b1, 1'b1, 1'b0, 32'h300, 4'hF});
    end
    n_checks++;
    if ({instr_ack, instr_data_o, data_ack, data_data_o} !== {1'b1, 32'h1234, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL prio_instr_ack: got %h expected %h", {instr_ack, instr_data_o, data_ack, data_data_o},
               {1'b1, 32'h1234, 1'b0, 32'h0});
    end
    tick();
    instr_req = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_ack_err();
    do_reset();
    data_req  = 1'b1;
    data_wr   = 1'b0;
    data_addr = 32'h44;
    data_be   = 4'hF;
    tick();
    mem_ack    = 1'b1;
    mem_err    = 1'b1;
    mem_data_i = 32'hAAAA_5555;
    @(negedge clk);
    n_checks++;
    if ({data_ack, data_err, data_data_o, instr_err} !== {1'b0, 1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL ack_err_both: got %h expected %h", {data_ack, data_err, data_data_o, instr_err},
               {1'b0, 1'b1, 32'h0, 1'b0});
    end
    tick();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_err_idle: got %b expected 0", busy);
    end
  endtask

  // Both requesters always asking, memory answers every cycle: D, I, D, I ...
  task automatic test_rr_alternate();
    logic [34:0] exp_v;
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h1000;
    data_req   = 1'b1;
    data_addr  = 32'h2000;
    data_be    = 4'hF;
    mem_ack    = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      mem_data_i = 32'h7000 + c;
      @(negedge clk);
      if (c == 0) exp_v = {1'b0, 1'b0, 1'b0, 32'h0};
      else if (c % 2 == 1) exp_v = {1'b1, 1'b1, 1'b0, 32'h2000};
      else exp_v = {1'b1, 1'b0, 1'b1, 32'h1000};
      n_checks++;
      if ({mem_req, data_ack, instr_ack, mem_addr} !== exp_v) begin
        n_fail++;
        $display("FAIL alternate_c%0d: got %h expected %h", c, {mem_req, data_ack, instr_ack, mem_addr}, exp_v);
      end
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_watchdog(input bit with_ack);
    logic [2:0] exp_v;
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        instr_req  = 1'b1;
        instr_addr = 32'h40;
      end
      if (c == 7) instr_req = 1'b0;
      mem_ack    = with_ack && (c == 6);
      mem_data_i = 32'h600D_0000 + c;
      @(negedge clk);
      exp_v = {(c >= 2 && c <= 6), (with_ack && c == 6), (!with_ack && c == 6)};
      n_checks++;
      if ({mem_req, instr_ack, instr_err} !== exp_v) begin
        n_fail++;
        $display("FAIL watchdog_ack%0d_c%0d: got %b expected %b", with_ack, c, {mem_req, instr_ack, instr_err}, exp_v);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    instr_req  = 1'b1;
    instr_addr = 32'h80;
    tick();
    #2;
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %b expected 1", mem_req);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, busy, instr_ack, instr_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got %b expected 0000", {mem_req, busy, instr_ack, instr_err});
    end
    instr_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    test_single_read("after_reset");
  endtask

  // Reference model works on transactions: who owns the port, how long it has waited,
  // and when the memory agent will answer.
  task automatic test_random(input int n_cycles);
    int          owner;
    int unsigned wt;
    int unsigned lat;
    int unsigned rtype;
    bit          i_pend, d_pend, i_done, d_done, last_d, pick_d, done, to_hit;
    logic        e_i_ack, e_i_err, e_d_ack, e_d_err;
    logic [31:0] e_i_data, e_d_data;
    logic [69:0] exp_resp, act_resp;
    logic [68:0] exp_cmd, act_cmd;
    do_reset();
    owner = 0; wt = 0; lat = 0; rtype = 0;
    i_pend = 0; d_pend = 0; i_done = 0; d_done = 0; last_d = 0;
    for (int c = 0; c < n_cycles; c++) begin
      if (c > 0) tick();
      if (i_done) begin i_pend = 0; instr_req = 1'b0; end
      if (d_done) begin d_pend = 0; data_req = 1'b0; end
      i_done = 0;
      d_done = 0;
      if (!i_pend && $urandom_range(2, 0) == 0) begin
        i_pend = 1; instr_req = 1'b1; instr_addr = $urandom;
      end
      if (!d_pend && $urandom_range(2, 0) == 0) begin
        d_pend = 1; data_req = 1'b1; data_wr = 1'($urandom_range(1, 0));
        data_be = 4'($urandom_range(15, 0)); data_addr = $urandom; data_data_i = $urandom;
      end
      mem_ack    = 1'b0;
      mem_err    = 1'b0;
      mem_data_i = $urandom;
      if (owner != 0) begin
        if (wt == lat) begin
          mem_ack = (rtype != 1);
          mem_err = (rtype != 0);
        end
      end else if ($urandom_range(7, 0) == 0) begin
        mem_ack = 1'b1;
        mem_err = 1'($urandom_range(1, 0));
      end
      to_hit   = (owner != 0) && (TO != 0) && (wt == TO);
      e_i_ack  = (owner == 1) && mem_ack && !mem_err;
      e_i_err  = (owner == 1) && (mem_err || (to_hit && !mem_ack));
      e_d_ack  = (owner == 2) && mem_ack && !mem_err;
      e_d_err  = (owner == 2) && (mem_err || (to_hit && !mem_ack));
      e_i_data = e_i_ack ? mem_data_i : 32'h0;
      e_d_data = e_d_ack ? mem_data_i : 32'h0;
      exp_resp = {owner != 0, owner != 0, e_i_ack, e_i_err, e_i_data, e_d_ack, e_d_err, e_d_data};
      @(negedge clk);
      act_resp = {mem_req, busy, instr_ack, instr_err, instr_data_o, data_ack, data_err, data_data_o};
      n_checks++;
      if (act_resp !== exp_resp) begin
        n_fail++;
        $display("FAIL random_resp_c%0d: got %h expected %h", c, act_resp, exp_resp);
      end
      if (owner != 0) begin
        exp_cmd = (owner == 1) ? {instr_addr, 1'b0, 4'hF, 32'h0} : {data_addr, data_wr, data_be, data_data_i};
        act_cmd = {mem_addr, mem_wr, mem_be, (owner == 2) ? mem_data_o : 32'h0};
        n_checks++;
        if (act_cmd !== exp_cmd) begin
          n_fail++;
          $display("FAIL random_cmd_c%0d: got %h expected %h", c, act_cmd, exp_cmd);
        end
      end
      if (owner == 0) begin
        if (i_pend || d_pend) begin
`ifdef RV32_MEM_ARB_ROUND_ROBIN_EN
          pick_d = d_pend && (!i_pend || !last_d);
`else
          pick_d = d_pend;
`endif
          owner = pick_d ? 2 : 1;
          wt = 0; lat = $urandom_range(6, 0); rtype = $urandom_range(2, 0); last_d = pick_d;
        end
      end else begin
        done = mem_ack || mem_err || to_hit;
        if (done) begin
          if (owner == 1) begin
            i_done = 1;
            owner  = d_pend ? 2 : 0;
          end else begin
            d_done = 1;
            owner  = i_pend ? 1 : 0;
          end
          if (owner != 0) begin
            wt = 0; lat = $urandom_range(6, 0); rtype = $urandom_range(2, 0); last_d = (owner == 2);
          end
        end else begin
          wt++;
        end
      end
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    do_reset();
    test_single_read("single");
    test_priority();
    test_ack_err();
    test_rr_alternate();
    test_watchdog(1'b0);
    test_watchdog(1'b1);
    test_reset_mid();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
